// File: rtl/sfft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sfft_pkg
//  Description : Shared constants, sample type, bank-state encoding and the
//                bit-reverse helper for the SFFT input framer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sfft_pkg;

   localparam int N     = 64;   // samples per frame (power of 2)
   localparam int LOG2N = 6;    // frame index width, log2(N)
   localparam int W     = 12;   // bits per real/imag component

   // One complex sample, two's complement components
   typedef struct packed {
      logic signed [W-1:0] re;
      logic signed [W-1:0] im;
   } sample_t;

   // Life cycle of one frame bank
   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_t;

   // Mirror the LOG2N-bit index so a frame leaves in bit-reversed order
   function automatic logic [LOG2N-1:0] bit_reverse(input logic [LOG2N-1:0] value);
      return {<<{value}};
   endfunction

endpackage
`default_nettype wire

// File: rtl/sfft_frame_bank.sv
`default_nettype none
// ============================================================================
//  Module      : sfft_frame_bank
//  Description : One N x 2W sample bank with single-slot write port and a
//                flat, fully registered read-out of every slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module sfft_frame_bank #(
   parameter int N     = 64,
   parameter int LOG2N = 6,
   parameter int W     = 12
) (
   input  logic             clk,
   input  logic             we,
   input  logic [LOG2N-1:0] widx,
   input  logic [W-1:0]     wre,
   input  logic [W-1:0]     wim,
   output logic [N*W-1:0]   rd_re,
   output logic [N*W-1:0]   rd_im
);

   logic [W-1:0] mem_re [N];
   logic [W-1:0] mem_im [N];

   // Slot storage; deliberately not reset so contents survive rst_n
   always_ff @(posedge clk) begin
      if (we) begin
         mem_re[widx] <= wre;
         mem_im[widx] <= wim;
      end
   end

   // Flatten slot k onto bits [k*W +: W]
   generate
      for (genvar k = 0; k < N; k++) begin : g_slot
         assign rd_re[k*W +: W] = mem_re[k];
         assign rd_im[k*W +: W] = mem_im[k];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/sfft_input_framer.sv
`default_nettype none
// ============================================================================
//  Module      : sfft_input_framer
//  Description : Serial valid/ready sample stream to ping-pong framed parallel
//                buses for the 64-point SFFT core. Optional macro
//                SFFT_BITREV_EN stores sample k at slot bitrev(k).
//  Revision    : 1.0 - initial release
// ============================================================================
module sfft_input_framer
   import sfft_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sof,
   input  logic [W-1:0]     in_re,
   input  logic [W-1:0]     in_im,
   output logic             frame_valid,
   input  logic             frame_ready,
   output logic [N*W-1:0]   frame_re,
   output logic [N*W-1:0]   frame_im,
   output logic [7:0]       drop_cnt
);

   bank_state_t      state_q [2];
   bank_state_t      state_d [2];
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [LOG2N-1:0] wr_idx_q, wr_idx_d;
   logic [7:0]       drop_cnt_q, drop_cnt_d;

   logic             wr_fire, rd_fire, restart, last;
   logic [LOG2N-1:0] idx_eff, wr_slot;
   sample_t          wr_sample;
   logic [N*W-1:0]   bank_re [2];
   logic [N*W-1:0]   bank_im [2];

   // Handshake status depends on registers only, never on in_valid
   assign in_ready    = (state_q[wr_bank_q] != BANK_FULL);
   assign frame_valid = (state_q[rd_bank_q] == BANK_FULL);
   assign wr_fire     = in_valid && in_ready;
   assign rd_fire     = frame_valid && frame_ready;
   assign wr_sample   = '{re: in_re, im: in_im};

   // Frame state register set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q[0] <= BANK_EMPTY;
         state_q[1] <= BANK_EMPTY;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         wr_idx_q   <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         wr_idx_q   <= wr_idx_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Next-state: read retire, write advance, start-of-frame resync
   always_comb begin
      state_d    = state_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      wr_idx_d   = wr_idx_q;
      drop_cnt_d = drop_cnt_q;

      // An SOF arriving mid-frame discards the partial frame and restarts at 0
      restart = wr_fire && in_sof && (wr_idx_q != '0);
      idx_eff = restart ? '0 : wr_idx_q;
      last    = wr_fire && (idx_eff == LOG2N'(N-1));

`ifdef SFFT_BITREV_EN
      wr_slot = bit_reverse(idx_eff);
`else
      wr_slot = idx_eff;
`endif

      // Retire first; a FULL write bank cannot be written, so no conflict
      if (rd_fire) begin
         state_d[rd_bank_q] = BANK_EMPTY;
         rd_bank_d          = ~rd_bank_q;
      end

      if (wr_fire) begin
         if (last) begin
            state_d[wr_bank_q] = BANK_FULL;
            wr_bank_d          = ~wr_bank_q;
            wr_idx_d           = '0;
         end else begin
            state_d[wr_bank_q] = BANK_FILLING;
            wr_idx_d           = idx_eff + LOG2N'(1);
         end
      end

      if (restart && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   // Ping-pong banks, each written only while it is the write bank
   generate
      for (genvar b = 0; b < 2; b++) begin : g_bank
         sfft_frame_bank #(
            .N     (N),
            .LOG2N (LOG2N),
            .W     (W)
         ) u_bank (
            .clk   (clk),
            .we    (wr_fire && (wr_bank_q == 1'(b))),
            .widx  (wr_slot),
            .wre   (wr_sample.re),
            .wim   (wr_sample.im),
            .rd_re (bank_re[b]),
            .rd_im (bank_im[b])
         );
      end
   endgenerate

   assign frame_re = bank_re[rd_bank_q];
   assign frame_im = bank_im[rd_bank_q];
   assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sfft_input_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sfft_input_framer
//  Description : Self-checking bench for sfft_input_framer with a queue-based
//                frame reference model. Honours SFFT_BITREV_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sfft_input_framer;
   import sfft_pkg::*;

   localparam int FW = N*W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_sof = 1'b0;
   logic          frame_ready = 1'b0;
   logic [W-1:0]  in_re = '0;
   logic [W-1:0]  in_im = '0;
   logic          in_ready;
   logic          frame_valid;
   logic [FW-1:0] frame_re;
   logic [FW-1:0] frame_im;
   logic [7:0]    drop_cnt;

   sfft_input_framer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sof      (in_sof),
      .in_re       (in_re),
      .in_im       (in_im),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .frame_re    (frame_re),
      .frame_im    (frame_im),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: frames waiting for the consumer, plus the one being built
   typedef struct packed {
      logic [FW-1:0] re;
      logic [FW-1:0] im;
   } frm_t;

   frm_t fq[$];
   frm_t cur;
   int   idx;
   int   drops;
   int   frames_out;
   int   accepted;
   int   checks;
   int   errors;
   logic [W-1:0] hist_re [0:255];

   // Where sample index k lands in the presented frame
   function automatic int slot_of(input int k);
      int r;
      r = 0;
      for (int b = 0; b < LOG2N; b++) begin
         if (((k >> b) & 1) != 0) r = r | (1 << (LOG2N - 1 - b));
      end
`ifdef SFFT_BITREV_EN
      return r;
`else
      return k;
`endif
   endfunction

   task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_write(input logic sof, input logic [W-1:0] re, input logic [W-1:0] im);
      if (sof && idx != 0) begin
         if (drops < 255) drops++;
         idx = 0;
      end
      cur.re[slot_of(idx)*W +: W] = re;
      cur.im[slot_of(idx)*W +: W] = im;
      if (idx == N-1) begin
         fq.push_back(cur);
         idx = 0;
      end else begin
         idx++;
      end
   endtask

   // One clock: drive, compare outputs with model, advance model on handshakes
   task automatic step(input logic v, input logic sof, input logic [W-1:0] re,
                       input logic [W-1:0] im, input logic fr);
      logic acc, facc;
      in_valid = v; in_sof = sof; in_re = re; in_im = im; frame_ready = fr;
      check("in_ready", FW'(in_ready), FW'(fq.size() < 2));
      check("frame_valid", FW'(frame_valid), FW'(fq.size() > 0));
      check("drop_cnt", FW'(drop_cnt), FW'(drops));
      if (fq.size() > 0) begin
         check("frame_re", frame_re, fq[0].re);
         check("frame_im", frame_im, fq[0].im);
      end
      acc  = v && (fq.size() < 2);
      facc = fr && (fq.size() > 0);
      @(posedge clk); #1;
      if (facc) begin
         void'(fq.pop_front());
         frames_out++;
      end
      if (acc) begin
         model_write(sof, re, im);
         accepted++;
      end
   endtask

   task automatic idle(input logic fr);
      step(1'b0, 1'b0, '0, '0, fr);
   endtask

   task automatic do_reset();
      in_valid = 1'b0; in_sof = 1'b0; frame_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      fq.delete(); idx = 0; drops = 0;
      check("rst_frame_valid", FW'(frame_valid), FW'(1'b0));
      check("rst_drop_cnt", FW'(drop_cnt), FW'(8'd0));
      check("rst_in_ready", FW'(in_ready), FW'(1'b1));
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int f0;
      logic [W-1:0] r, m;
      checks = 0; errors = 0; frames_out = 0; accepted = 0;
      cur = '0;

      // --- Reset state
      do_reset();
      idle(1'b0);

      // --- First frame: re = k*16, im = 0, consumer not ready
      for (int k = 0; k < N; k++) step(1'b1, 1'b0, W'(k*16), '0, 1'b0);
      check("t1_valid_after_last", FW'(frame_valid), FW'(1'b1));
      check("t1_slot5", FW'(frame_re[5*W +: W]), FW'(W'(slot_of(5)*16)));
      check("t1_in_ready_bank1_empty", FW'(in_ready), FW'(1'b1));
      idle(1'b0);
      idle(1'b1);

      // --- Two frames back-to-back with no consumer; then stall and release
      do_reset();
      for (int k = 0; k < 2*N; k++) begin
         r = W'($urandom); m = W'($urandom);
         hist_re[k] = r;
         step(1'b1, 1'b0, r, m, 1'b0);
      end
      check("t2_in_ready_low_both_full", FW'(in_ready), FW'(1'b0));
      r = W'($urandom); m = W'($urandom);
      for (int s = 0; s < 3; s++) step(1'b1, 1'b0, r, m, 1'b0);
      step(1'b1, 1'b0, r, m, 1'b1);
      check("t2_in_ready_after_retire", FW'(in_ready), FW'(1'b1));
      check("t2_second_frame_slot0", FW'(frame_re[0 +: W]), FW'(hist_re[N]));
      step(1'b1, 1'b0, r, m, 1'b0);
      idle(1'b1);

      // --- Continuous stream with consumer always ready
      do_reset();
      f0 = frames_out; accepted = 0;
      for (int k = 0; k < 4*N; k++) begin
         check("t3_no_stall", FW'(in_ready), FW'(1'b1));
         step(1'b1, 1'b0, W'($urandom), W'($urandom), 1'b1);
      end
      idle(1'b1);
      check("t3_accepted", FW'(accepted), FW'(4*N));
      check("t3_frames", FW'(frames_out - f0), FW'(4));

      // --- Mid-frame SOF discards the partial frame
      do_reset();
      for (int k = 0; k < 10; k++) step(1'b1, 1'b0, W'($urandom), W'($urandom), 1'b0);
      step(1'b1, 1'b1, 12'h7FF, 12'h123, 1'b0);
      check("t4_drop_cnt", FW'(drop_cnt), FW'(8'd1));
      for (int k = 1; k < N; k++) step(1'b1, 1'b0, W'($urandom), W'($urandom), 1'b0);
      check("t4_slot0", FW'(frame_re[0 +: W]), FW'(12'h7FF));

      // --- Asynchronous reset mid-frame with a frame still presented
      for (int k = 0; k < 30; k++) step(1'b1, 1'b0, W'($urandom), W'($urandom), 1'b0);
      do_reset();
      for (int k = 0; k < N; k++) step(1'b1, 1'b0, W'($urandom), W'($urandom), 1'b0);
      check("t5_clean_frame", FW'(frame_valid), FW'(1'b1));
      idle(1'b1);

      // --- Value k at index k: exposes natural or bit-reversed order
      do_reset();
      for (int k = 0; k < N; k++) step(1'b1, 1'b0, W'(k), W'(N - k), 1'b0);
      check("t6_slot1", FW'(frame_re[1*W +: W]), FW'(W'(slot_of(1))));
      check("t6_slot32", FW'(frame_re[32*W +: W]), FW'(W'(slot_of(32))));
      idle(1'b1);

      // --- Random traffic: bursty valid, lazy consumer, occasional SOF
      do_reset();
      for (int k = 0; k < 600; k++) begin
         step(($urandom % 4) != 0, ($urandom % 20) == 0, W'($urandom), W'($urandom),
              ($urandom % 3) == 0);
      end
      for (int k = 0; k < 4; k++) idle(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
